// File: rtl/alu_checker.sv
// Scoreboard for a 4-bit ALU: predicts each checked result, delays it by LAT cycles,
// and compares it against the observed ALU output, keeping pass/fail stats and the first failure.
module alu_checker #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             chk_valid,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       alu_out,
    output logic             busy,
    output logic             mismatch,
    output logic             err_flag,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [1:0]       ff_op,
    output logic [3:0]       ff_exp,
    output logic [3:0]       ff_got
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;
    logic [1:0] drain_q, drain_d;

    logic       dl_valid_q [LAT];
    logic [3:0] dl_exp_q   [LAT];
    logic [1:0] dl_op_q    [LAT];

    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic             err_q, err_d;
    logic [1:0]       ffop_q, ffop_d;
    logic [3:0]       ffexp_q, ffexp_d, ffgot_q, ffgot_d;

    logic [3:0] exp_now;
    logic       sample, clear;
    logic       cmp_valid, pass_hit, fail_hit;

    always_comb begin
        exp_now = 4'h0;
        case (alu_op)
            2'b00:   exp_now = a + b;
            2'b01:   exp_now = a - b;
            2'b10:   exp_now = a & b;
            default: exp_now = a | b;
        endcase
    end

    // Reset discards the compare at the tail of the delay line in the same cycle.
    assign cmp_valid = dl_valid_q[LAT-1] && !rst;
    assign pass_hit  = cmp_valid && (alu_out == dl_exp_q[LAT-1]);
    assign fail_hit  = cmp_valid && (alu_out != dl_exp_q[LAT-1]);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        sample  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            StRun: begin
                sample = chk_valid;
                if (stop) begin
                    state_d = StDrain;
                    drain_d = 2'(LAT - 1);
                end
            end
            StDrain: begin
                if (drain_q == 2'd0) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        ffop_d  = ffop_q;
        ffexp_d = ffexp_q;
        ffgot_d = ffgot_q;
        if (clear) begin
            pass_d  = '0;
            fail_d  = '0;
            err_d   = 1'b0;
            ffop_d  = 2'b00;
            ffexp_d = 4'h0;
            ffgot_d = 4'h0;
        end else begin
            if (pass_hit && (pass_q != '1)) begin
                pass_d = pass_q + CNT_W'(1);
            end
            if (fail_hit) begin
                if (fail_q != '1) begin
                    fail_d = fail_q + CNT_W'(1);
                end
                if (!err_q) begin
                    err_d   = 1'b1;
                    ffop_d  = dl_op_q[LAT-1];
                    ffexp_d = dl_exp_q[LAT-1];
                    ffgot_d = alu_out;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            drain_q <= 2'd0;
            pass_q  <= '0;
            fail_q  <= '0;
            err_q   <= 1'b0;
            ffop_q  <= 2'b00;
            ffexp_q <= 4'h0;
            ffgot_q <= 4'h0;
            for (int i = 0; i < LAT; i++) begin
                dl_valid_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            ffop_q  <= ffop_d;
            ffexp_q <= ffexp_d;
            ffgot_q <= ffgot_d;
            dl_valid_q[0] <= sample;
            for (int i = 1; i < LAT; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is only consumed when its valid bit is set.
    always_ff @(posedge clk) begin
        dl_exp_q[0] <= exp_now;
        dl_op_q[0]  <= alu_op;
        for (int i = 1; i < LAT; i++) begin
            dl_exp_q[i] <= dl_exp_q[i-1];
            dl_op_q[i]  <= dl_op_q[i-1];
        end
    end

    assign busy     = (state_q != StIdle);
    assign mismatch = fail_hit;
    assign err_flag = err_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign ff_op    = ffop_q;
    assign ff_exp   = ffexp_q;
    assign ff_got   = ffgot_q;

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: two instances (LAT=1 and LAT=3) driven in lockstep and checked
// against a cycle-scheduled reference model, a directed vector table and corner sequences.
module tb_alu_checker;

    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       rst, start, stop, chk_valid;
    logic [3:0] a, b;
    logic [1:0] alu_op;
    logic [3:0] alu_out_w [2];
    logic       busy_w [2];
    logic       mm_w [2];
    logic       err_w [2];
    logic [7:0] pass_w [2];
    logic [7:0] fail_w [2];
    logic [1:0] ffop_w [2];
    logic [3:0] ffexp_w [2];
    logic [3:0] ffgot_w [2];

    always #5 clk = ~clk;

    alu_checker #(.LAT(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .chk_valid(chk_valid),
        .a(a), .b(b), .alu_op(alu_op), .alu_out(alu_out_w[0]),
        .busy(busy_w[0]), .mismatch(mm_w[0]), .err_flag(err_w[0]),
        .pass_cnt(pass_w[0]), .fail_cnt(fail_w[0]),
        .ff_op(ffop_w[0]), .ff_exp(ffexp_w[0]), .ff_got(ffgot_w[0])
    );

    alu_checker #(.LAT(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .chk_valid(chk_valid),
        .a(a), .b(b), .alu_op(alu_op), .alu_out(alu_out_w[1]),
        .busy(busy_w[1]), .mismatch(mm_w[1]), .err_flag(err_w[1]),
        .pass_cnt(pass_w[1]), .fail_cnt(fail_w[1]),
        .ff_op(ffop_w[1]), .ff_exp(ffexp_w[1]), .ff_got(ffgot_w[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each sample is scheduled into the slot of the cycle it is due in.
    logic       sv [2][8];
    logic [3:0] se [2][8];
    logic [1:0] so [2][8];
    int m_samp [2], m_drain [2], m_pass [2], m_fail [2];
    int m_err [2], m_fop [2], m_fexp [2], m_fgot [2];
    int cyc = 0;
    int mm_seen [2];
    logic bad [2];
    logic force1;
    logic [3:0] force_val;

    typedef struct {
        int st, sp, cv, a, b, op, ao;
        int mm, busy, pass, fail, err, ffop, ffexp, ffgot;
    } vec_t;
    vec_t tbl [17];

    function automatic logic [3:0] ref_alu(input int x, input int y, input int op);
        int r;
        case (op)
            0:       r = (x + y) % 16;
            1:       r = (x - y + 16) % 16;
            2:       r = x & y;
            default: r = x | y;
        endcase
        return 4'(r);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic rand_ops();
        a      = 4'($urandom);
        b      = 4'($urandom);
        alu_op = 2'($urandom);
    endtask

    // One clock cycle: drive alu_out, check mismatch mid-cycle, advance model, check state.
    task automatic tick();
        int slot;
        int s2;
        int lat;
        logic busy_now;
        slot = cyc % 8;
        for (int d = 0; d < 2; d++) begin
            if (sv[d][slot]) begin
                alu_out_w[d] = bad[d] ? (se[d][slot] ^ 4'($urandom_range(1, 15))) : se[d][slot];
            end else begin
                alu_out_w[d] = 4'($urandom);
            end
        end
        if (force1) alu_out_w[0] = force_val;
        #3;
        for (int d = 0; d < 2; d++) begin
            mm_seen[d] = int'(mm_w[d]);
            chk($sformatf("mismatch[%0d] cyc %0d", d, cyc), mm_seen[d],
                int'(!rst && sv[d][slot] && (alu_out_w[d] != se[d][slot])));
        end
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            if (rst) begin
                for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
                m_samp[d] = 0; m_drain[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
                m_err[d] = 0; m_fop[d] = 0; m_fexp[d] = 0; m_fgot[d] = 0;
            end else begin
                if (sv[d][slot]) begin
                    if (alu_out_w[d] == se[d][slot]) begin
                        if (m_pass[d] < CMAX) m_pass[d]++;
                    end else begin
                        if (m_fail[d] < CMAX) m_fail[d]++;
                        if (m_err[d] == 0) begin
                            m_err[d]  = 1;
                            m_fop[d]  = int'(so[d][slot]);
                            m_fexp[d] = int'(se[d][slot]);
                            m_fgot[d] = int'(alu_out_w[d]);
                        end
                    end
                end
                sv[d][slot] = 1'b0;
                busy_now = (m_samp[d] != 0) || (m_drain[d] > 0);
                if (m_samp[d] != 0 && chk_valid) begin
                    s2 = (cyc + lat) % 8;
                    sv[d][s2] = 1'b1;
                    se[d][s2] = ref_alu(int'(a), int'(b), int'(alu_op));
                    so[d][s2] = alu_op;
                end
                if (!busy_now && start) begin
                    m_pass[d] = 0; m_fail[d] = 0; m_err[d] = 0;
                    m_fop[d] = 0; m_fexp[d] = 0; m_fgot[d] = 0;
                    m_samp[d] = 1;
                end else if (m_samp[d] != 0 && stop) begin
                    m_samp[d]  = 0;
                    m_drain[d] = lat;
                end else if (m_drain[d] > 0) begin
                    m_drain[d]--;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy[%0d] cyc %0d", d, cyc), int'(busy_w[d]),
                int'((m_samp[d] != 0) || (m_drain[d] > 0)));
            chk($sformatf("pass_cnt[%0d] cyc %0d", d, cyc), int'(pass_w[d]), m_pass[d]);
            chk($sformatf("fail_cnt[%0d] cyc %0d", d, cyc), int'(fail_w[d]), m_fail[d]);
            chk($sformatf("err_flag[%0d] cyc %0d", d, cyc), int'(err_w[d]), m_err[d]);
            chk($sformatf("ff_op[%0d] cyc %0d", d, cyc), int'(ffop_w[d]), m_fop[d]);
            chk($sformatf("ff_exp[%0d] cyc %0d", d, cyc), int'(ffexp_w[d]), m_fexp[d]);
            chk($sformatf("ff_got[%0d] cyc %0d", d, cyc), int'(ffgot_w[d]), m_fgot[d]);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; chk_valid = 1'b0;
        bad[0] = 1'b0; bad[1] = 1'b0; force1 = 1'b0;
    endtask

    initial begin
        int n;
        // LAT=1 directed vectors: st sp cv a b op alu_out | mm busy pass fail err ff_op ff_exp ff_got
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 4, 6, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 4, 6, 1, 10,  0, 1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 4, 6, 2, 14,  0, 1, 2, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 4, 6, 3, 4,   0, 1, 3, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 6,   0, 1, 4, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 4, 6, 1, 0,   0, 1, 4, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 4, 6, 0, 2,   1, 1, 4, 1, 1, 1, 14, 2};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,   1, 1, 4, 2, 1, 1, 14, 2};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 3,   0, 1, 4, 2, 1, 1, 14, 2};
        tbl[10] = '{0, 0, 1, 15, 1, 0, 0,  0, 1, 4, 2, 1, 1, 14, 2};
        tbl[11] = '{0, 0, 1, 0, 1, 1, 0,   0, 1, 5, 2, 1, 1, 14, 2};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 15,  0, 1, 6, 2, 1, 1, 14, 2};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 0,   0, 1, 6, 2, 1, 1, 14, 2};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 6, 2, 1, 1, 14, 2};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 6, 2, 1, 1, 14, 2};
        tbl[16] = '{1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                sv[d][k] = 1'b0; se[d][k] = 4'h0; so[d][k] = 2'b00;
            end
            m_samp[d] = 0; m_drain[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
            m_err[d] = 0; m_fop[d] = 0; m_fexp[d] = 0; m_fgot[d] = 0;
            alu_out_w[d] = 4'h0; bad[d] = 1'b0;
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; chk_valid = 1'b0;
        a = 4'h0; b = 4'h0; alu_op = 2'b00; force1 = 1'b0; force_val = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b1; tick();
        rst = 1'b1; tick();

        for (int i = 0; i < 17; i++) begin
            start     = (tbl[i].st != 0);
            stop      = (tbl[i].sp != 0);
            chk_valid = (tbl[i].cv != 0);
            a         = 4'(tbl[i].a);
            b         = 4'(tbl[i].b);
            alu_op    = 2'(tbl[i].op);
            force1    = 1'b1;
            force_val = 4'(tbl[i].ao);
            tick();
            chk($sformatf("tbl%0d mismatch", i), mm_seen[0], tbl[i].mm);
            chk($sformatf("tbl%0d busy", i), int'(busy_w[0]), tbl[i].busy);
            chk($sformatf("tbl%0d pass_cnt", i), int'(pass_w[0]), tbl[i].pass);
            chk($sformatf("tbl%0d fail_cnt", i), int'(fail_w[0]), tbl[i].fail);
            chk($sformatf("tbl%0d err_flag", i), int'(err_w[0]), tbl[i].err);
            chk($sformatf("tbl%0d ff_op", i), int'(ffop_w[0]), tbl[i].ffop);
            chk($sformatf("tbl%0d ff_exp", i), int'(ffexp_w[0]), tbl[i].ffexp);
            chk($sformatf("tbl%0d ff_got", i), int'(ffgot_w[0]), tbl[i].ffgot);
        end

        // LAT=3: a sample taken with stop is still counted after three drain cycles.
        rst = 1'b1; tick();
        start = 1'b1; tick();
        chk_valid = 1'b1; rand_ops(); tick();
        chk_valid = 1'b1; rand_ops(); tick();
        stop = 1'b1; chk_valid = 1'b1; rand_ops(); tick();
        chk("drain busy at stop", int'(busy_w[1]), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("drain busy %0d", k), int'(busy_w[1]), (k < 2) ? 1 : 0);
        end
        chk("drain pass_cnt", int'(pass_w[1]), 3);
        chk("drain fail_cnt", int'(fail_w[1]), 0);

        // LAT=3: reset with two compares in flight discards them.
        rst = 1'b1; tick();
        start = 1'b1; tick();
        chk_valid = 1'b1; rand_ops(); tick();
        chk_valid = 1'b1; rand_ops(); tick();
        rst = 1'b1; start = 1'b1; chk_valid = 1'b1; rand_ops(); tick();
        for (int k = 0; k < 4; k++) begin
            bad[0] = 1'b1; bad[1] = 1'b1; tick();
            chk($sformatf("post-rst mismatch %0d", k), mm_seen[1], 0);
        end
        chk("post-rst busy", int'(busy_w[1]), 0);
        chk("post-rst pass_cnt", int'(pass_w[1]), 0);
        chk("post-rst fail_cnt", int'(fail_w[1]), 0);
        chk("post-rst err_flag", int'(err_w[1]), 0);

        // Saturation: 300 passing checks.
        rst = 1'b1; tick();
        start = 1'b1; tick();
        for (int k = 0; k < 300; k++) begin
            chk_valid = 1'b1; rand_ops(); tick();
        end
        stop = 1'b1; tick();
        repeat (4) tick();
        chk("sat pass_cnt lat1", int'(pass_w[0]), 255);
        chk("sat pass_cnt lat3", int'(pass_w[1]), 255);
        chk("sat fail_cnt lat3", int'(fail_w[1]), 0);

        // Random traffic with injected faults, stray starts/stops and occasional reset.
        n = 0;
        repeat (800) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 15) == 0);
            stop      = ($urandom_range(0, 19) == 0);
            chk_valid = ($urandom_range(0, 3) != 0);
            bad[0]    = ($urandom_range(0, 5) == 0);
            bad[1]    = ($urandom_range(0, 5) == 0);
            rand_ops();
            tick();
            n++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
